// File: rtl/memory_access_unit.sv
// Memory access unit: turns single CPU load/store requests into RAM strobes,
// stalls the pipeline while a load is in flight and flags illegal addresses.
module memory_access_unit #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              addr_err,
    output logic [31:0]       err_addr,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [31:0]       ram_q
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        DONE
    } state_t;

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t     state;
    logic [1:0] cnt;
    logic       legal;
    logic       accept;
    logic       illegal_req;

    // Word aligned and inside the RAM window.
    assign legal       = (req_addr[1:0] == 2'b00) && ((req_addr >> (ADDR_W + 2)) == 32'd0);
    assign accept      = (state == IDLE) && req_valid && legal;
    assign illegal_req = (state == IDLE) && req_valid && !legal;

    // Handshake and strobes are pure decodes of the FSM state (plus the
    // accept cycle for stall); stall is gated by reset so it reads 0 while
    // reset is asserted even if a legal request is presented.
    assign req_ready = (state == IDLE);
    assign stall     = reset && (accept || (state == READ_WAIT));
    assign ram_wren  = (state == WRITE);
    assign ram_rden  = (state == READ_WAIT) && (cnt == LAT);
    assign ld_valid  = (state == DONE);

    // Request FSM: capture address/data on accept, count out the read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ld_data     <= '0;
            ram_address <= '0;
            ram_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ram_address <= req_addr[ADDR_W+1:2];
                        ram_data    <= req_wdata;
                        if (req_write) begin
                            state <= WRITE;
                        end else begin
                            state <= READ_WAIT;
                            cnt   <= LAT;
                        end
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                READ_WAIT: begin
                    if (cnt == 2'd0) begin
                        ld_data <= ram_q;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky illegal-address flag; a new illegal request beats err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_err <= 1'b0;
            err_addr <= '0;
        end else if (illegal_req) begin
            addr_err <= 1'b1;
            err_addr <= req_addr;
        end else if (err_clr) begin
            addr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Testbench for memory_access_unit: directed table, corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_memory_access_unit;

    localparam int ADDR_W = 10;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              stall;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              addr_err;
    logic [31:0]       err_addr;
    logic              err_clr;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_data;
    logic              ram_rden;
    logic              ram_wren;
    logic [31:0]       ram_q;

    memory_access_unit #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
        .addr_err(addr_err), .err_addr(err_addr), .err_clr(err_clr),
        .ram_address(ram_address), .ram_data(ram_data), .ram_rden(ram_rden), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model with RD_LAT read pipeline ----------------
    logic        ram_init;
    logic [31:0] ram [DEPTH];
    logic [31:0] pd  [RD_LAT];

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 4) return 32'h1234_5678;
        return (i * 32'h9E37_79B1) ^ 32'hC3C3_0000;
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
        end else if (ram_wren) begin
            ram[ram_address] <= ram_data;
        end
    end

    always @(posedge clk) begin
        pd[0] <= ram_rden ? ram[ram_address] : 32'hBAD0_BAD0;
        for (int i = 1; i < RD_LAT; i++) pd[i] <= pd[i-1];
    end
    assign ram_q = pd[RD_LAT-1];

    int unsigned rd_count = 0;
    int unsigned ld_count = 0;
    always @(posedge clk) begin
        if (ram_rden) rd_count <= rd_count + 1;
        if (ld_valid) ld_count <= ld_count + 1;
    end

    // ---------------- reference model state ----------------
    logic [31:0] refmem [DEPTH];
    logic [31:0] exp_ld;
    logic        exp_err;
    logic [31:0] exp_err_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < (32'd1 << (ADDR_W + 2)));
    endfunction

    // One complete request from the IDLE cycle until back in IDLE.
    // Entry and exit point: 1 time unit after a rising edge.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic hold, input logic exp_legal, input logic [31:0] exp_rd,
                          input string tag);
        int unsigned rd_before;
        int unsigned idx;
        idx       = (addr / 4) % DEPTH;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        chk({tag, " idle ready"}, 32'(req_ready), 32'd1);
        chk({tag, " accept stall"}, 32'(stall), 32'(exp_legal));
        chk({tag, " idle strobes"}, {30'd0, ram_rden, ram_wren}, 32'd0);
        chk({tag, " idle ld_valid"}, 32'(ld_valid), 32'd0);
        chk({tag, " ld_data held"}, ld_data, exp_ld);
        chk({tag, " addr_err before"}, 32'(addr_err), 32'(exp_err));
        chk({tag, " err_addr before"}, err_addr, exp_err_addr);
        rd_before = rd_count;
        @(posedge clk); #1;
        if (!exp_legal) begin
            req_valid    = 1'b0;
            exp_err      = 1'b1;
            exp_err_addr = addr;
            @(negedge clk);
            chk({tag, " err set"}, 32'(addr_err), 32'd1);
            chk({tag, " err_addr"}, err_addr, addr);
            chk({tag, " illegal stays idle"}, 32'(req_ready), 32'd1);
            chk({tag, " illegal no strobe"}, {30'd0, ram_rden, ram_wren, stall}, 32'd0);
            @(posedge clk); #1;
        end else if (wr) begin
            if (!hold) req_valid = 1'b0;
            @(negedge clk);
            chk({tag, " wren"}, 32'(ram_wren), 32'd1);
            chk({tag, " write no rden/stall/ready"}, {29'd0, ram_rden, stall, req_ready}, 32'd0);
            chk({tag, " ram_address"}, 32'(ram_address), idx);
            chk({tag, " ram_data"}, ram_data, wd);
            refmem[idx] = wd;
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk({tag, " store reads"}, rd_count - rd_before, 32'd0);
        end else begin
            if (!hold) req_valid = 1'b0;
            for (int k = 0; k <= RD_LAT; k++) begin
                @(negedge clk);
                chk({tag, " wait stall"}, 32'(stall), 32'd1);
                chk({tag, " wait ready"}, 32'(req_ready), 32'd0);
                chk({tag, " wait rden"}, 32'(ram_rden), 32'(k == 0));
                chk({tag, " wait wren/ld_valid"}, {30'd0, ram_wren, ld_valid}, 32'd0);
                if (k == 0) chk({tag, " rd address"}, 32'(ram_address), idx);
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk({tag, " ld_valid"}, 32'(ld_valid), 32'd1);
            chk({tag, " ld_data"}, ld_data, exp_rd);
            chk({tag, " done no stall/ready/strobe"},
                {28'd0, stall, req_ready, ram_rden, ram_wren}, 32'd0);
            exp_ld = exp_rd;
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk({tag, " reads per load"}, rd_count - rd_before, 32'd1);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_legal;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned ld_before;
        int unsigned rd_before;
        int unsigned mode;
        logic [31:0] a;
        logic        w;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,          1'b1, 32'h1234_5678};
        vecs[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  1'b1, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,          1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h0000_0006, 32'h0,          1'b0, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_1000, 32'h0,          1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_0001,  1'b1, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_0FFC, 32'h0,          1'b1, 32'hA5A5_0001};
        vecs[7] = '{1'b1, 32'h8000_0000, 32'h1111_2222,  1'b0, 32'h0};
        vecs[8] = '{1'b0, 32'h0000_0000, 32'h0,          1'b1, 32'hC3C3_0000};

        for (int i = 0; i < DEPTH; i++) refmem[i] = init_word(i);
        exp_ld       = '0;
        exp_err      = 1'b0;
        exp_err_addr = '0;

        reset     = 1'b0;
        ram_init  = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(req_ready), 32'd1);
        chk("reset stall/strobes/ld_valid", {28'd0, stall, ram_rden, ram_wren, ld_valid}, 32'd0);
        chk("reset ld_data", ld_data, 32'd0);
        chk("reset addr_err", 32'(addr_err), 32'd0);
        chk("reset err_addr", err_addr, 32'd0);
        chk("reset ram_address", 32'(ram_address), 32'd0);
        chk("reset ram_data", ram_data, 32'd0);
        @(posedge clk); #1;
        reset    = 1'b1;
        ram_init = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0,
                   vecs[i].exp_legal, vecs[i].exp_rd, $sformatf("vec%0d", i));
        end

        // req_valid held through a load and through a store
        do_txn(1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b1, refmem[4], "hold load");
        do_txn(1'b1, 32'h0000_0040, 32'h5555_AAAA, 1'b1, 1'b1, 32'h0, "hold store");

        // err_clr alone, then err_clr together with a new illegal request
        do_txn(1'b0, 32'h0000_0006, 32'h0, 1'b0, 1'b0, 32'h0, "err set");
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        chk("err_clr clears", 32'(addr_err), 32'd0);
        chk("err_clr keeps err_addr", err_addr, 32'h0000_0006);
        @(posedge clk); #1;
        err_clr   = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_2001;
        @(negedge clk);
        chk("set vs clr stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        err_clr   = 1'b0;
        req_valid = 1'b0;
        exp_err      = 1'b1;
        exp_err_addr = 32'h0000_2001;
        @(negedge clk);
        chk("set wins addr_err", 32'(addr_err), 32'd1);
        chk("set wins err_addr", err_addr, 32'h0000_2001);
        @(posedge clk); #1;

        // Reset asserted during READ_WAIT
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0020;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async rst ready", 32'(req_ready), 32'd1);
        chk("async rst stall/strobes/ld_valid", {28'd0, stall, ram_rden, ram_wren, ld_valid}, 32'd0);
        chk("async rst ld_data", ld_data, 32'd0);
        chk("async rst addr_err", 32'(addr_err), 32'd0);
        chk("async rst err_addr", err_addr, 32'd0);
        chk("async rst ram_address/data", {22'd0, ram_address} | ram_data, 32'd0);
        ld_before = ld_count;
        rd_before = rd_count;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (RD_LAT + 4) @(posedge clk);
        #1;
        chk("no ld_valid after abort", ld_count - ld_before, 32'd0);
        chk("no read after abort", rd_count - rd_before, 32'd0);
        exp_ld       = '0;
        exp_err      = 1'b0;
        exp_err_addr = '0;

        // Randomized transactions
        for (int n = 0; n < 300; n++) begin
            mode = $urandom_range(0, 9);
            if (mode < 8)       a = {20'd0, 10'($urandom), 2'b00};
            else if (mode == 8) a = {20'd0, 10'($urandom), 2'($urandom_range(1, 3))};
            else                a = $urandom | 32'h0000_1000;
            w = 1'($urandom);
            do_txn(w, a, $urandom, 1'($urandom), is_legal(a),
                   refmem[(a / 4) % DEPTH], $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) begin
                req_valid = 1'b0;
                req_addr  = $urandom;
                req_write = 1'($urandom);
                @(negedge clk);
                chk("gap idle", {29'd0, req_ready, stall, ld_valid}, 32'd4);
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
